// File: rtl/fft_frame_scheduler_pkg.sv
`default_nettype none
// =====================================================================
// Package  : fft_frame_scheduler_pkg
// Brief    : Frame geometry defaults and scheduler state encoding,
//            shared with the VGA spectrum visualizer.
// Revision : 1.0 - initial release
// =====================================================================
package fft_frame_scheduler_pkg;

    localparam int DEF_N_BINS      = 512;
    localparam int DEF_ADDR_W      = 9;
    localparam int DEF_MAG_W       = 24;
    localparam int DEF_DECAY_SHIFT = 4;

    typedef enum logic [2:0] {
        ST_CLEAR     = 3'd0,
        ST_SYNC      = 3'd1,
        ST_COLLECT   = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_WAIT_SWAP = 3'd4
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_frame_scheduler_ram.sv
`default_nettype none
// =====================================================================
// Module   : peak_hold_ram
// Brief    : Single-clock peak memory, one synchronous read port and
//            one write port. A same-address read returns the old word.
// Revision : 1.0 - initial release
// =====================================================================
import fft_frame_scheduler_pkg::*;

module peak_hold_ram #(
    parameter int DEPTH  = DEF_N_BINS,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_MAG_W
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Registered read and write; contents are initialised by the CLEAR sweep
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_frame_scheduler.sv
`default_nettype none
// =====================================================================
// Module   : fft_frame_scheduler
// Brief    : Accepts in-order FFT magnitude frames, applies peak-hold
//            with exponential decay, forwards bins to the visualizer
//            and issues one bank-swap pulse per complete frame.
// Revision : 1.0 - initial release
// =====================================================================
import fft_frame_scheduler_pkg::*;

module fft_frame_scheduler #(
    parameter int N_BINS      = DEF_N_BINS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int MAG_W       = DEF_MAG_W,
    parameter int DECAY_SHIFT = DEF_DECAY_SHIFT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_fft_addr,
    input  logic [MAG_W-1:0]  i_fft_mag,
    input  logic              i_fft_valid,
    input  logic              i_vsync_tick,
    input  logic              i_peak_en,
    output logic [ADDR_W-1:0] o_vis_addr,
    output logic [MAG_W-1:0]  o_vis_mag,
    output logic              o_vis_valid,
    output logic              o_swap,
    output logic              o_busy,
    output logic [15:0]       o_drop_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_BINS - 1);

    sched_state_t      state, state_next;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_next;
    logic [ADDR_W-1:0] expected, expected_next;
    logic              drain_cnt, drain_cnt_next;
    logic              accept, swap_next, drop_hit;

    logic              s1_valid, s1_peak_en, s1_fwd;
    logic [ADDR_W-1:0] s1_addr;
    logic [MAG_W-1:0]  s1_mag, s1_fwd_data;
    logic [MAG_W-1:0]  rd_data, peak, held, out_mag;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [MAG_W-1:0]  wr_data;

    assign o_busy = (state == ST_CLEAR);

    // State register and frame bookkeeping counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            expected  <= '0;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_next;
            clr_cnt   <= clr_cnt_next;
            expected  <= expected_next;
            drain_cnt <= drain_cnt_next;
        end
    end

    // Next-state logic: bin acceptance, frame ordering, drop and swap decisions
    always_comb begin
        state_next     = state;
        clr_cnt_next   = clr_cnt;
        expected_next  = expected;
        drain_cnt_next = drain_cnt;
        accept         = 1'b0;
        swap_next      = 1'b0;
        drop_hit       = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_cnt_next = clr_cnt + 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (i_fft_valid && (i_fft_addr == '0)) begin
                    accept        = 1'b1;
                    expected_next = ADDR_W'(1);
                    state_next    = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (i_fft_valid) begin
                    if (i_fft_addr == expected) begin
                        accept        = 1'b1;
                        expected_next = expected + 1'b1;
                        if (expected == LAST_ADDR) begin
                            drain_cnt_next = 1'b0;
                            state_next     = ST_DRAIN;
                        end
                    end else if (i_fft_addr == '0) begin
                        // Out-of-order addr 0 starts a fresh frame
                        accept        = 1'b1;
                        expected_next = ADDR_W'(1);
                    end else begin
                        state_next = ST_SYNC;
                    end
                end
            end
            ST_DRAIN: begin
                drop_hit       = i_fft_valid && (i_fft_addr == '0);
                drain_cnt_next = 1'b1;
                if (drain_cnt) begin
                    state_next = ST_WAIT_SWAP;
                end
            end
            ST_WAIT_SWAP: begin
                drop_hit = i_fft_valid && (i_fft_addr == '0);
                if (i_vsync_tick) begin
                    swap_next  = 1'b1;
                    state_next = ST_SYNC;
                end
            end
            default: begin
                state_next = ST_CLEAR;
            end
        endcase
    end

    // Stage 1: hold the accepted bin while the RAM fetches its stored peak.
    // A restart can revisit the address still being written, so that case
    // takes the in-flight result instead of the stale RAM word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_peak_en  <= 1'b0;
            s1_addr     <= '0;
            s1_mag      <= '0;
            s1_fwd      <= 1'b0;
            s1_fwd_data <= '0;
        end else begin
            s1_valid    <= accept;
            s1_fwd      <= accept && s1_valid && (s1_addr == i_fft_addr);
            s1_fwd_data <= out_mag;
            if (accept) begin
                s1_addr    <= i_fft_addr;
                s1_mag     <= i_fft_mag;
                s1_peak_en <= i_peak_en;
            end
        end
    end

    // Stage 2 arithmetic: decayed peak, then max against the new magnitude
    always_comb begin
        peak    = s1_fwd ? s1_fwd_data : rd_data;
        held    = peak - (peak >> DECAY_SHIFT);
        out_mag = (s1_peak_en && (held > s1_mag)) ? held : s1_mag;
    end

    // RAM write port is owned by the CLEAR sweep, otherwise by stage 2
    always_comb begin
        wr_en   = s1_valid;
        wr_addr = s1_addr;
        wr_data = out_mag;
        if (state == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt;
            wr_data = '0;
        end
    end

    peak_hold_ram #(
        .DEPTH  (N_BINS),
        .ADDR_W (ADDR_W),
        .DATA_W (MAG_W)
    ) u_peak_ram (
        .clk     (clk),
        .rd_en   (accept),
        .rd_addr (i_fft_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    // Stage 2 register: visualizer write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_vis_valid <= 1'b0;
            o_vis_addr  <= '0;
            o_vis_mag   <= '0;
        end else begin
            o_vis_valid <= s1_valid;
            if (s1_valid) begin
                o_vis_addr <= s1_addr;
                o_vis_mag  <= out_mag;
            end
        end
    end

    // Swap pulse and saturating dropped-frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_swap     <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            o_swap <= swap_next;
            if (drop_hit && (o_drop_cnt != 16'hFFFF)) begin
                o_drop_cnt <= o_drop_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire
